// File: rtl/dma_pkg.sv
// Shared types and constants for the descriptor-chain sequencer.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PROG,
        ST_WAIT_DONE,
        ST_ACK,
        ST_WAIT_CLR,
        ST_NEXT,
        ST_ENG_RST
    } state_t;

    // Sequencer CSR offsets
    localparam logic [3:0] CSR_CTRL  = 4'd0;
    localparam logic [3:0] CSR_CMD   = 4'd1;
    localparam logic [3:0] CSR_HEAD  = 4'd2;
    localparam logic [3:0] CSR_COUNT = 4'd3;
    localparam logic [3:0] CSR_CUR   = 4'd4;

    // dma_engine CSR offsets
    localparam logic [3:0] ENG_CTRL = 4'd0;
    localparam logic [3:0] ENG_CMD  = 4'd1;
    localparam logic [3:0] ENG_SRC  = 4'd2;
    localparam logic [3:0] ENG_DST  = 4'd3;
    localparam logic [3:0] ENG_CNT  = 4'd4;

    // dma_engine command values
    localparam logic [31:0] CMD_GO_IRQ  = 32'h3;
    localparam logic [31:0] CMD_IRQ_CLR = 32'h2;
    localparam logic [31:0] CMD_RST     = 32'h1;

    // Descriptor word indices and LAST flag position in the next word
    localparam logic [1:0] DW_SRC  = 2'd0;
    localparam logic [1:0] DW_DST  = 2'd1;
    localparam logic [1:0] DW_CNT  = 2'd2;
    localparam logic [1:0] DW_NEXT = 2'd3;
    localparam int         LAST_BIT = 0;

    typedef logic [3:0][31:0] desc_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } eng_wr_t;

    // Engine programming sequence: src, dst, count, then go with irq enabled.
    function automatic eng_wr_t prog_step(input logic [1:0] idx, input desc_t d);
        eng_wr_t w;
        case (idx)
            2'd0:    begin w.addr = ENG_SRC;  w.data = d[DW_SRC]; end
            2'd1:    begin w.addr = ENG_DST;  w.data = d[DW_DST]; end
            2'd2:    begin w.addr = ENG_CNT;  w.data = {16'b0, d[DW_CNT][15:0]}; end
            default: begin w.addr = ENG_CTRL; w.data = CMD_GO_IRQ; end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dma_sequencer_if.sv
// Bus bundle for the sequencer: CPU CSR slave, descriptor fetch master,
// engine CSR write master and the engine interrupt.
interface dma_sequencer_if;
    logic [3:0]  s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        s_read;
    logic        s_write;
    logic        s_waitrequest;
    logic        s_irq;

    logic [31:0] md_address;
    logic        md_read;
    logic [31:0] md_readdata;
    logic        md_waitrequest;

    logic [3:0]  mc_address;
    logic [31:0] mc_writedata;
    logic        mc_write;
    logic        mc_waitrequest;

    logic        dma_irq;

    // Sequencer side
    modport slave (
        input  s_address, s_writedata, s_read, s_write,
        output s_readdata, s_waitrequest, s_irq,
        output md_address, md_read,
        input  md_readdata, md_waitrequest,
        output mc_address, mc_writedata, mc_write,
        input  mc_waitrequest,
        input  dma_irq
    );

    // CPU / memory / engine side
    modport master (
        output s_address, s_writedata, s_read, s_write,
        input  s_readdata, s_waitrequest, s_irq,
        input  md_address, md_read,
        output md_readdata, md_waitrequest,
        input  mc_address, mc_writedata, mc_write,
        output mc_waitrequest,
        output dma_irq
    );
endinterface

// File: rtl/dma_sequencer_csr.sv
// CPU-facing CSR block: decode, one-wait-state reads, irq state, START/ABORT pulses.
module dma_sequencer_csr
    import dma_pkg::*;
(
    input  logic        clock,
    input  logic        clock_areset_n,
    input  logic [3:0]  s_address,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    input  logic        s_write,
    output logic [31:0] s_readdata,
    output logic        s_waitrequest,
    output logic        s_irq,
    input  logic        busy,
    input  logic        chain_done,
    input  logic [31:0] done_count,
    input  logic [31:0] cur_addr,
    output logic [31:0] head,
    output logic        start,
    output logic        abort
);
    logic        rd_phase;
    logic        irq_en;
    logic        irq_pending;
    logic        wr_ctrl;
    logic        wr_cmd;
    logic [31:0] rd_mux;

    assign wr_ctrl       = s_write && (s_address == CSR_CTRL);
    assign wr_cmd        = s_write && (s_address == CSR_CMD);
    assign start         = wr_ctrl && s_writedata[0];
    assign abort         = wr_cmd && s_writedata[0];
    assign s_waitrequest = s_read && !rd_phase;
    assign s_irq         = irq_pending && irq_en;

    // Read data selection; command register and unmapped offsets read 0.
    always_comb begin
        rd_mux = '0;
        case (s_address)
            CSR_CTRL:  rd_mux = {29'b0, irq_pending, busy, irq_en};
            CSR_HEAD:  rd_mux = head;
            CSR_COUNT: rd_mux = done_count;
            CSR_CUR:   rd_mux = cur_addr;
            default:   rd_mux = '0;
        endcase
    end

    // Read handshake: stall the first cycle, present registered data on the second.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            rd_phase   <= 1'b0;
            s_readdata <= '0;
        end else if (s_read && !rd_phase) begin
            rd_phase   <= 1'b1;
            s_readdata <= rd_mux;
        end else begin
            rd_phase   <= 1'b0;
        end
    end

    // Writable state; a chain completion beats a simultaneous IRQ_CLEAR.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            irq_en      <= 1'b0;
            irq_pending <= 1'b0;
            head        <= '0;
        end else begin
            if (wr_ctrl)
                irq_en <= s_writedata[1];
            if (s_write && (s_address == CSR_HEAD))
                head <= {s_writedata[31:2], 2'b00};
            if (chain_done)
                irq_pending <= 1'b1;
            else if (wr_cmd && s_writedata[1])
                irq_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/dma_sequencer.sv
// Descriptor-chain sequencer: fetches linked descriptors and drives dma_engine.
module dma_sequencer
    import dma_pkg::*;
(
    input  logic           clock,
    input  logic           clock_areset_n,
    dma_sequencer_if.slave bus
);
    state_t      state, state_nxt;
    desc_t       desc;
    logic [1:0]  wcnt;
    logic [31:0] cur, head, done_count;
    logic        start, abort, abort_pend, abort_any;
    logic        md_acc, mc_acc, md_issue, mc_issue;
    logic        busy, chain_done, last;
    eng_wr_t     mc_req;
    logic        unused_bits;

    assign busy        = (state != ST_IDLE);
    assign md_acc      = bus.md_read && !bus.md_waitrequest;
    assign mc_acc      = bus.mc_write && !bus.mc_waitrequest;
    assign abort_any   = abort_pend || abort;
    assign last        = desc[DW_NEXT][LAST_BIT];
    assign chain_done  = (state == ST_NEXT) && last;
    assign unused_bits = ^{desc[DW_CNT][31:16], desc[DW_NEXT][1]};

    dma_sequencer_csr u_csr (
        .clock          (clock),
        .clock_areset_n (clock_areset_n),
        .s_address      (bus.s_address),
        .s_writedata    (bus.s_writedata),
        .s_read         (bus.s_read),
        .s_write        (bus.s_write),
        .s_readdata     (bus.s_readdata),
        .s_waitrequest  (bus.s_waitrequest),
        .s_irq          (bus.s_irq),
        .busy           (busy),
        .chain_done     (chain_done),
        .done_count     (done_count),
        .cur_addr       (cur),
        .head           (head),
        .start          (start),
        .abort          (abort)
    );

    // State register.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) state <= ST_IDLE;
        else                 state <= state_nxt;
    end

    // Next state and transfer issue; a new transfer only starts with the strobe low.
    always_comb begin
        state_nxt = state;
        md_issue  = 1'b0;
        mc_issue  = 1'b0;
        mc_req    = prog_step(wcnt, desc);
        case (state)
            ST_IDLE:
                if (start) state_nxt = ST_FETCH;
            ST_FETCH:
                if (md_acc && wcnt == 2'd3) begin
                    if (abort_any)                        state_nxt = ST_IDLE;
                    else if (desc[DW_CNT][15:0] == 16'd0) state_nxt = ST_NEXT;
                    else                                  state_nxt = ST_PROG;
                end else if (!bus.md_read) begin
                    if (abort_any) state_nxt = ST_IDLE;
                    else           md_issue  = 1'b1;
                end
            ST_PROG:
                if (mc_acc && wcnt == 2'd3) begin
                    state_nxt = abort_any ? ST_IDLE : ST_WAIT_DONE;
                end else if (!bus.mc_write) begin
                    if (abort_any) state_nxt = ST_IDLE;
                    else           mc_issue  = 1'b1;
                end
            ST_WAIT_DONE:
                if (abort_any)        state_nxt = ST_ENG_RST;
                else if (bus.dma_irq) state_nxt = ST_ACK;
            ST_ACK: begin
                mc_req = '{addr: ENG_CMD, data: CMD_IRQ_CLR};
                if (mc_acc) begin
                    state_nxt = abort_any ? ST_IDLE : ST_WAIT_CLR;
                end else if (!bus.mc_write) begin
                    if (abort_any) state_nxt = ST_IDLE;
                    else           mc_issue  = 1'b1;
                end
            end
            ST_WAIT_CLR:
                if (abort_any)         state_nxt = ST_ENG_RST;
                else if (!bus.dma_irq) state_nxt = ST_NEXT;
            ST_NEXT:
                if (last || abort_any) state_nxt = ST_IDLE;
                else                   state_nxt = ST_FETCH;
            ST_ENG_RST: begin
                mc_req = '{addr: ENG_CMD, data: CMD_RST};
                if (mc_acc)              state_nxt = ST_IDLE;
                else if (!bus.mc_write)  mc_issue  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: word counter, descriptor latch, registered masters, pointers.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            wcnt             <= '0;
            desc             <= '0;
            cur              <= '0;
            done_count       <= '0;
            abort_pend       <= 1'b0;
            bus.md_read      <= 1'b0;
            bus.md_address   <= '0;
            bus.mc_write     <= 1'b0;
            bus.mc_address   <= '0;
            bus.mc_writedata <= '0;
        end else begin
            if (state_nxt != state)      wcnt <= '0;
            else if (md_acc || mc_acc)   wcnt <= wcnt + 2'd1;

            if (md_acc) desc[wcnt] <= bus.md_readdata;

            if (md_issue) begin
                bus.md_read    <= 1'b1;
                bus.md_address <= cur + {28'b0, wcnt, 2'b00};
            end else if (md_acc) begin
                bus.md_read    <= 1'b0;
            end

            if (mc_issue) begin
                bus.mc_write     <= 1'b1;
                bus.mc_address   <= mc_req.addr;
                bus.mc_writedata <= mc_req.data;
            end else if (mc_acc) begin
                bus.mc_write     <= 1'b0;
            end

            if (state == ST_IDLE && start) begin
                cur        <= head;
                done_count <= '0;
            end else if (state == ST_NEXT) begin
                done_count <= done_count + 32'd1;
                if (state_nxt == ST_FETCH) cur <= {desc[DW_NEXT][31:2], 2'b00};
            end

            if (state_nxt == ST_IDLE)  abort_pend <= 1'b0;
            else if (abort && busy)    abort_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_sequencer.sv
// Directed bench for dma_sequencer with memory and dma_engine responder models.
module tb_dma_sequencer;
    import dma_pkg::*;

    logic clock = 1'b0;
    logic clock_areset_n = 1'b0;
    always #5 clock = ~clock;

    dma_sequencer_if bus();

    dma_sequencer dut (
        .clock          (clock),
        .clock_areset_n (clock_areset_n),
        .bus            (bus)
    );

    int vecs = 0;
    int errs = 0;

    // Descriptor memory with programmable wait states
    logic [31:0] mem [0:255];
    int md_wait_n = 0, md_wc = 0, n_fetch = 0;
    assign bus.md_readdata    = mem[bus.md_address[9:2]];
    assign bus.md_waitrequest = bus.md_read && (md_wc < md_wait_n);
    always @(posedge clock) begin
        if (bus.md_read && bus.md_waitrequest) md_wc <= md_wc + 1;
        else                                   md_wc <= 0;
        if (bus.md_read && !bus.md_waitrequest) n_fetch <= n_fetch + 1;
    end

    // Engine model: logs writes, raises irq some cycles after GO, drops it on command writes
    int mc_wait_n = 0, mc_wc = 0, n_log = 0, irq_cnt = 0;
    int irq_delay = 4;
    bit eng_hold = 1'b0, armed = 1'b0;
    logic dma_irq_m = 1'b0;
    logic [3:0]  log_a [0:127];
    logic [31:0] log_d [0:127];
    assign bus.mc_waitrequest = bus.mc_write && (mc_wc < mc_wait_n);
    assign bus.dma_irq        = dma_irq_m;
    always @(posedge clock) begin
        if (bus.mc_write && bus.mc_waitrequest) mc_wc <= mc_wc + 1;
        else                                    mc_wc <= 0;
        if (bus.mc_write && !bus.mc_waitrequest) begin
            if (n_log < 128) begin
                log_a[n_log] <= bus.mc_address;
                log_d[n_log] <= bus.mc_writedata;
            end
            n_log <= n_log + 1;
            if (bus.mc_address == 4'd0 && bus.mc_writedata == 32'h3) begin
                armed   <= 1'b1;
                irq_cnt <= irq_delay;
            end
            if (bus.mc_address == 4'd1) begin
                dma_irq_m <= 1'b0;
                armed     <= 1'b0;
            end
        end else if (armed && !eng_hold) begin
            if (irq_cnt == 0) begin
                dma_irq_m <= 1'b1;
                armed     <= 1'b0;
            end else begin
                irq_cnt <= irq_cnt - 1;
            end
        end
    end

    // Stability of held master transfers and s_irq rising-edge count
    bit md_hold = 1'b0, mc_hold = 1'b0, sirq_q = 1'b0;
    logic [31:0] md_ha, mc_hd;
    logic [3:0]  mc_ha;
    int md_stab_err = 0, mc_stab_err = 0, irq_rises = 0;
    always @(posedge clock) begin
        sirq_q <= bus.s_irq;
        if (bus.s_irq && !sirq_q) irq_rises <= irq_rises + 1;
        if (!clock_areset_n) begin
            md_hold <= 1'b0;
            mc_hold <= 1'b0;
        end else begin
            if (md_hold && (!bus.md_read || bus.md_address !== md_ha))
                md_stab_err <= md_stab_err + 1;
            if (mc_hold && (!bus.mc_write || bus.mc_address !== mc_ha || bus.mc_writedata !== mc_hd))
                mc_stab_err <= mc_stab_err + 1;
            md_hold <= bus.md_read && bus.md_waitrequest;
            md_ha   <= bus.md_address;
            mc_hold <= bus.mc_write && bus.mc_waitrequest;
            mc_ha   <= bus.mc_address;
            mc_hd   <= bus.mc_writedata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [3:0] a, input logic [31:0] d);
        check({tag, " addr"}, {28'b0, log_a[idx]}, {28'b0, a});
        check({tag, " data"}, log_d[idx], d);
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.s_address   = a;
        bus.s_writedata = d;
        bus.s_write     = 1'b1;
        @(negedge clock);
        bus.s_write     = 1'b0;
    endtask

    bit rd_first_wait;
    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        n = 0;
        @(negedge clock);
        bus.s_address = a;
        bus.s_read    = 1'b1;
        #1 rd_first_wait = bus.s_waitrequest;
        @(negedge clock);
        while (bus.s_waitrequest && n < 4) begin
            @(negedge clock);
            n++;
        end
        d = bus.s_waitrequest ? 32'hDEAD_BEEF : bus.s_readdata;
        bus.s_read = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output logic [31:0] st);
        int n;
        n = 0;
        do begin
            cpu_read(CSR_CTRL, st);
            n++;
        end while (st[1] && n < 400);
        check({tag, " busy cleared"}, {31'b0, st[1]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int base, fbase, rbase, n;

        bus.s_address = '0; bus.s_writedata = '0; bus.s_read = 1'b0; bus.s_write = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        // single descriptor at 0x40
        mem['h40>>2] = 32'h1000; mem['h44>>2] = 32'h2000; mem['h48>>2] = 32'd8;  mem['h4C>>2] = 32'h1;
        // chain 0x100 -> 0x200 -> 0x300 (LAST)
        mem['h100>>2] = 32'hA0; mem['h104>>2] = 32'hB0; mem['h108>>2] = 32'd4; mem['h10C>>2] = 32'h200;
        mem['h200>>2] = 32'hA1; mem['h204>>2] = 32'hB1; mem['h208>>2] = 32'd5; mem['h20C>>2] = 32'h300;
        mem['h300>>2] = 32'hA2; mem['h304>>2] = 32'hB2; mem['h308>>2] = 32'd6; mem['h30C>>2] = 32'h1;

        // reset state
        repeat (3) @(negedge clock);
        check("rst md_read", {31'b0, bus.md_read}, 32'd0);
        check("rst mc_write", {31'b0, bus.mc_write}, 32'd0);
        check("rst md_address", bus.md_address, 32'd0);
        check("rst mc_writedata", bus.mc_writedata, 32'd0);
        check("rst s_readdata", bus.s_readdata, 32'd0);
        check("rst s_waitrequest", {31'b0, bus.s_waitrequest}, 32'd0);
        check("rst s_irq", {31'b0, bus.s_irq}, 32'd0);
        clock_areset_n = 1'b1;
        cpu_read(CSR_CTRL, d);  check("rst status", d, 32'd0);
        check("read first-cycle wait", {31'b0, rd_first_wait}, 32'd1);
        cpu_read(CSR_COUNT, d); check("rst count", d, 32'd0);

        // single descriptor, head low bits forced to zero
        cpu_write(CSR_HEAD, 32'h43);
        cpu_read(CSR_HEAD, d);  check("head align", d, 32'h40);
        cpu_read(CSR_CMD, d);   check("cmd reads 0", d, 32'd0);
        base = n_log; fbase = n_fetch;
        cpu_write(CSR_CTRL, 32'h3);
        wait_idle("t1", d);
        check("t1 status", d, 32'h5);
        check("t1 writes", n_log - base, 32'd5);
        chk_log("t1 w0", base + 0, 4'd2, 32'h1000);
        chk_log("t1 w1", base + 1, 4'd3, 32'h2000);
        chk_log("t1 w2", base + 2, 4'd4, 32'd8);
        chk_log("t1 w3", base + 3, 4'd0, 32'h3);
        chk_log("t1 ack", base + 4, 4'd1, 32'h2);
        check("t1 fetches", n_fetch - fbase, 32'd4);
        cpu_read(CSR_COUNT, d); check("t1 count", d, 32'd1);
        cpu_read(CSR_CUR, d);   check("t1 cur", d, 32'h40);
        check("t1 s_irq", {31'b0, bus.s_irq}, 32'd1);
        cpu_write(CSR_CMD, 32'h2);
        check("t1 s_irq cleared", {31'b0, bus.s_irq}, 32'd0);

        // chain of three
        cpu_write(CSR_HEAD, 32'h100);
        base = n_log; fbase = n_fetch; rbase = irq_rises;
        cpu_write(CSR_CTRL, 32'h3);
        wait_idle("t2", d);
        check("t2 writes", n_log - base, 32'd15);
        check("t2 fetches", n_fetch - fbase, 32'd12);
        chk_log("t2 d1 src", base + 5, 4'd2, 32'hA1);
        chk_log("t2 d1 cnt", base + 7, 4'd4, 32'd5);
        chk_log("t2 d2 dst", base + 11, 4'd3, 32'hB2);
        chk_log("t2 d2 go", base + 13, 4'd0, 32'h3);
        cpu_read(CSR_COUNT, d); check("t2 count", d, 32'd3);
        cpu_read(CSR_CUR, d);   check("t2 cur", d, 32'h300);
        check("t2 one irq", irq_rises - rbase, 32'd1);
        cpu_write(CSR_CMD, 32'h2);

        // zero-count middle descriptor, all bus transfers stalled 5 cycles
        mem['h208>>2] = 32'd0;
        md_wait_n = 5; mc_wait_n = 5;
        base = n_log; fbase = n_fetch;
        cpu_write(CSR_CTRL, 32'h3);
        wait_idle("t3", d);
        check("t3 writes", n_log - base, 32'd10);
        check("t3 fetches", n_fetch - fbase, 32'd12);
        chk_log("t3 d0 ack", base + 4, 4'd1, 32'h2);
        chk_log("t3 d2 src", base + 5, 4'd2, 32'hA2);
        chk_log("t3 d2 cnt", base + 7, 4'd4, 32'd6);
        cpu_read(CSR_COUNT, d); check("t3 count", d, 32'd3);
        check("t3 md stable", md_stab_err, 32'd0);
        check("t3 mc stable", mc_stab_err, 32'd0);
        md_wait_n = 0; mc_wait_n = 0;
        cpu_write(CSR_CMD, 32'h2);

        // abort while waiting for the engine
        cpu_write(CSR_HEAD, 32'h40);
        eng_hold = 1'b1;
        base = n_log;
        cpu_write(CSR_CTRL, 32'h3);
        n = 0;
        while (n_log - base < 4 && n < 200) begin @(negedge clock); n++; end
        check("t4 programmed", n_log - base, 32'd4);
        repeat (3) @(negedge clock);
        cpu_write(CSR_CMD, 32'h1);
        wait_idle("t4", d);
        check("t4 status", d, 32'h1);
        check("t4 writes", n_log - base, 32'd5);
        chk_log("t4 eng rst", base + 4, 4'd1, 32'h1);
        check("t4 s_irq", {31'b0, bus.s_irq}, 32'd0);
        cpu_read(CSR_COUNT, d); check("t4 count", d, 32'd0);
        eng_hold = 1'b0;
        base = n_log;
        cpu_write(CSR_CTRL, 32'h3);
        wait_idle("t4 rerun", d);
        check("t4 rerun writes", n_log - base, 32'd5);
        chk_log("t4 rerun w0", base, 4'd2, 32'h1000);
        cpu_read(CSR_COUNT, d); check("t4 rerun count", d, 32'd1);
        check("t4 rerun s_irq", {31'b0, bus.s_irq}, 32'd1);

        // asynchronous reset in the middle of a fetch
        md_wait_n = 5;
        cpu_write(CSR_HEAD, 32'h100);
        cpu_write(CSR_CTRL, 32'h3);
        n = 0;
        while (!bus.md_read && n < 50) begin @(negedge clock); n++; end
        check("t5 fetch started", {31'b0, bus.md_read}, 32'd1);
        #2 clock_areset_n = 1'b0;
        #1;
        check("t5 md_read", {31'b0, bus.md_read}, 32'd0);
        check("t5 md_address", bus.md_address, 32'd0);
        check("t5 mc_address", {28'b0, bus.mc_address}, 32'd0);
        check("t5 mc_writedata", bus.mc_writedata, 32'd0);
        check("t5 s_irq", {31'b0, bus.s_irq}, 32'd0);
        check("t5 s_readdata", bus.s_readdata, 32'd0);
        repeat (2) @(negedge clock);
        clock_areset_n = 1'b1;
        md_wait_n = 0;
        repeat (3) @(negedge clock);
        check("t5 md idle", {31'b0, bus.md_read}, 32'd0);
        cpu_read(CSR_CTRL, d);  check("t5 status", d, 32'd0);
        cpu_read(CSR_COUNT, d); check("t5 count", d, 32'd0);
        cpu_read(CSR_HEAD, d);  check("t5 head", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dma_sequencer.md
# dma_sequencer

Descriptor-chain sequencer directly upstream of `dma_engine`. Fetches 4-word linked descriptors from memory and programs `dma_engine`'s CSR slave over its own Avalon-MM master: read pointer, write pointer and word count, then go with irq enabled. It waits for the engine's irq, acknowledges it, and follows the next pointer. This lets the CPU queue whole frame or line transfers with one start write.

## Interface
- No parameters. Descriptor layout, engine register map and fixed widths are package constants.
- `clock` in 1: single clock.
- `clock_areset_n` in 1: asynchronous, active-low reset.
- `s_address` in 4, `s_writedata` in 32, `s_readdata` out 32, `s_read` in 1, `s_write` in 1, `s_waitrequest` out 1: CPU CSR slave.
- `s_irq` out 1: chain-complete interrupt.
- `md_address` out 32, `md_read` out 1, `md_readdata` in 32, `md_waitrequest` in 1: descriptor fetch master. Data is valid in the cycle where `md_read & ~md_waitrequest`.
- `mc_address` out 4, `mc_writedata` out 32, `mc_write` out 1, `mc_waitrequest` in 1: write-only master to `dma_engine` CSR.
- `dma_irq` in 1: `dma_engine` `s_irq`.

## Operation
- Descriptor at 4-byte-aligned address A:
  - word0 (A+0): src pointer.
  - word1 (A+4): dst pointer.
  - word2 (A+8): 16-bit word count.
  - word3 (A+12): next pointer; bit0 = LAST; next address = word3 & ~32'h3.
- CSR map:
  - 0 ctrl/status. Write: bit0 START, bit1 IRQ_EN. Read: {29'b0, irq_pending, busy, irq_en}.
  - 1 command, write-only. bit0 ABORT, bit1 IRQ_CLEAR. Reads 0.
  - 2 head pointer, R/W. Bits[1:0] are forced to 0.
  - 3 completed-descriptor count, RO, 32-bit. Cleared on START, wraps at 2^32.
  - 4 current descriptor address, RO.
- FSM states and transitions:
  - IDLE: on START, load cur ← head, clear count, set busy, go to FETCH. START while busy is ignored.
  - FETCH: four sequential reads at cur+0/4/8/12, words latched in order. Exit: if count==0, go to NEXT (skip, engine untouched). Otherwise go to PROG.
  - PROG: four writes to engine, in order:
    - addr 2 ← src
    - addr 3 ← dst
    - addr 4 ← count
    - addr 0 ← 32'h3 (go + irq enable)
    - Then go to WAIT_DONE.
  - WAIT_DONE: wait for `dma_irq`=1, then go to ACK.
  - ACK: write addr 1 ← 32'h2 (engine irq clear), then go to WAIT_CLR.
  - WAIT_CLR: wait for `dma_irq`=0, then go to NEXT.
  - NEXT: increment completed count (skipped descriptors count too).
    - If LAST: clear busy, set irq_pending, go to IDLE.
    - Otherwise: cur ← next, go to FETCH.
- `s_irq` = irq_pending & irq_en. IRQ_CLEAR clears irq_pending. If set and clear occur in the same cycle, set wins.
- ABORT, latched as pending:
  - In FETCH/PROG/ACK: finish the in-flight bus transfer, then go to IDLE with no further transfers.
  - In WAIT_DONE/WAIT_CLR: issue one write addr 1 ← 32'h1 (engine reset), then go to IDLE.
  - Abort clears busy and does not set irq_pending. ABORT in IDLE is a no-op.
- Head pointer writes while busy only affect the next START.

## Timing
- Reset values:
  - all master `*_read`/`*_write` = 0
  - `md_address`/`mc_address`/`mc_writedata` = 0
  - `s_readdata` = 0, `s_waitrequest` = 0, `s_irq` = 0
  - busy = 0, irq_en = 0, head = 0, count = 0, state = IDLE
- CSR slave:
  - Writes complete in zero wait states.
  - Reads assert `s_waitrequest` for exactly the first cycle. Data is registered and valid on the second cycle.
- Masters:
  - Address, data and strobe are registered and held stable while `*_waitrequest`=1.
  - Strobe deasserts the cycle after acceptance.
  - One transfer outstanding at a time.
- Minimum gaps:
  - START write to first `md_read`: 1 cycle.
  - Last fetch accept to first `mc_write`: 1 cycle.
  - Fetch of the next descriptor starts 1 cycle after NEXT.
- Back-to-back `dma_irq` toggles are each observed. No edge detection; level waits only.
- Reset assertion mid-transfer drops all strobes immediately and asynchronously. The engine must be reset separately by system reset.

## Structure
- `dma_pkg`: state enum, CSR offsets for both blocks, engine command values (GO_IRQ=3, IRQ_CLR=2, RST=1), descriptor word indices, LAST bit position.
- One sub-module, `dma_sequencer_csr`: slave decode, read-latency handshake, irq_pending/irq_en, START/ABORT pulses. The FSM and masters live in the top.

## Test plan
- Single descriptor {src 0x1000, dst 0x2000, count 8, next 0x1 (LAST)} → engine writes 2:0x1000, 3:0x2000, 4:8, 0:3. Model `dma_irq` → ack write 1:2 → count=1, `s_irq`=1 when irq_en=1.
- Chain of 3 at 0x100→0x200→0x300 (LAST on third) → 12 fetches, 3 programming sequences, count=3, one `s_irq`.
- Middle descriptor with count 0 → no engine writes for it; count still 3.
- ABORT during WAIT_DONE → exactly one write 1:1, busy=0, `s_irq` stays 0. Next START re-runs from head.
- `md_waitrequest`/`mc_waitrequest` held 5 cycles → address/data stable throughout, no duplicate transfers.
- `clock_areset_n` low mid-FETCH → all outputs at reset values immediately. After release: IDLE, busy=0.
